bist_sequencer: RTL

Built-in self-test sequencer for the Project 5 equation datapath. On request, it drives a fixed number of LFSR-generated operand pairs into the datapath, alternating the equation select. It compacts the returned results into an 8-bit MISR signature and compares that signature against a golden value. Its `bist_active` / `bist_pass` outputs feed the system controller, which gates normal operation on a passing self-test.

---
 rtl/bist_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: built-in self-test sequencer for the equation datapath.
// Drives NUM_PATTERNS LFSR operand pairs into the datapath and alternates the
// equation select. It compacts the returned results into an 8-bit MISR and
// compares the final signature against GOLDEN_SIG.
// Optional feature: define BIST_AUTO_START_EN to launch a run automatically on
// the first edge after reset deasserts.
module bist_sequencer #(
  parameter int         NUM_PATTERNS = 16,          // 2..255
  parameter int         DUT_LAT      = 1,           // 1..4
  parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_bist,
  input  logic [7:0] dut_result,
  output logic [7:0] dut_a,
  output logic [7:0] dut_b,
  output logic       sel_eq,
  output logic       vec_valid,
  output logic       bist_active,
  output logic       bist_done,
  output logic       bist_pass,
  output logic [7:0] signature
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [7:0]  LAST_PAT   = 8'(NUM_PATTERNS - 1);
  localparam logic [1:0]  LAST_DRAIN = 2'(DUT_LAT - 1);

  logic [2:0]         state;
  logic [15:0]        lfsr;
  logic [7:0]         misr;
  logic [7:0]         pat_cnt;
  logic [1:0]         drain_cnt;
  logic [DUT_LAT-1:0] vpipe;      // vec_valid delayed to line up with dut_result
  logic               done_q;
  logic               pass_q;
  logic               start_req;
  logic               lfsr_fb;
  logic               misr_fb;

`ifdef BIST_AUTO_START_EN
  logic auto_pend;

  // Pending auto-start: set during reset, consumed on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) auto_pend <= 1'b1;
    else     auto_pend <= 1'b0;
  end

  assign start_req = start_bist | auto_pend;
`else
  assign start_req = start_bist;
`endif

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign misr_fb = misr[7] ^ misr[5] ^ misr[4] ^ misr[3];

  // Sequencer FSM, LFSR, pattern/drain counters, valid pipe and MISR.
  // NOTE: every register here uses non-blocking assignment so that all state
  // updates see the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_SEED;
      misr      <= 8'h00;
      pat_cnt   <= 8'h00;
      drain_cnt <= 2'd0;
      vpipe     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      vpipe[0] <= vec_valid;
      for (int i = 1; i < DUT_LAT; i++) vpipe[i] <= vpipe[i-1];
      if (vpipe[DUT_LAT-1]) misr <= {misr[6:0], misr_fb} ^ dut_result;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            // Later assignments to misr/vpipe override the defaults above.
            state     <= S_RUN;
            lfsr      <= LFSR_SEED;
            misr      <= 8'h00;
            pat_cnt   <= 8'h00;
            drain_cnt <= 2'd0;
            vpipe     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        S_RUN: begin
          lfsr    <= {lfsr[14:0], lfsr_fb};
          pat_cnt <= pat_cnt + 8'd1;
          if (pat_cnt == LAST_PAT) begin
            state     <= S_DRAIN;
            drain_cnt <= 2'd0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == LAST_DRAIN) state <= S_COMPARE;
        end
        S_COMPARE: begin
          pass_q <= (misr == GOLDEN_SIG);
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Vector outputs are live only in RUN; zero everywhere else.
  // NOTE: each output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dut_a     = 8'h00;
    dut_b     = 8'h00;
    sel_eq    = 1'b0;
    vec_valid = 1'b0;
    if (state == S_RUN) begin
      dut_a     = lfsr[15:8];
      dut_b     = lfsr[7:0];
      sel_eq    = pat_cnt[0];
      vec_valid = 1'b1;
    end
  end

  assign bist_active = (state == S_RUN) || (state == S_DRAIN) || (state == S_COMPARE);
  assign bist_done   = done_q;
  assign bist_pass   = pass_q;
  assign signature   = misr;

endmodule
